rs_error_corrector: RTL

Final stage of the RS(255,239) decoder, directly downstream of the Chien search and Forney error-value evaluator. It buffers the received codeword while syndromes, Berlekamp-Massey and the Chien search run. It then consumes the per-symbol error-location flag and error magnitude and XORs them into the buffered symbols to emit the corrected stream. It also counts located errors per frame and checks them against the error-locator degree to flag decode failure.

---
 rtl/rs_error_corrector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rs_error_corrector.sv
// RS(255,239) error corrector: buffers received symbols, XORs in Chien/Forney error values.
// Optional frame status (error count, degree check) is built when RS_CORR_STATUS_EN is defined.
module rs_error_corrector #(
  parameter int N = 255,
  parameter int K = 239,
  parameter int T = 8,
  parameter int M = 8
) (
  input  logic         clk_in,
  input  logic         sys_rst_n,
  input  logic         rx_valid,
  input  logic         rx_sof,
  input  logic [M-1:0] rx_data,
  input  logic         ecc_valid,
  input  logic         ecc_sof,
  input  logic         err_flag,
  input  logic [M-1:0] err_mag,
  input  logic         lambda_deg_valid,
  input  logic [3:0]   lambda_deg,
  output logic         out_valid,
  output logic         out_sof,
  output logic         out_eof,
  output logic         out_msg,
  output logic [M-1:0] out_data,
  output logic         frame_done,
  output logic         decode_fail,
  output logic [7:0]   err_count,
  output logic         buf_full,
  output logic         ovf_err,
  output logic         align_err
);
  localparam int          DEPTH    = 512;
  localparam logic [7:0]  LAST_IDX = 8'(N - 1);
  localparam logic [7:0]  MSG_END  = 8'(K);
  localparam logic [3:0]  T_MAX    = 4'(T);
  localparam logic [9:0]  OCC_FULL = 10'(DEPTH);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [M-1:0] mem [DEPTH];

  state_t       state_q, state_d;
  logic [8:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0]   occ_q, occ_d;
  logic [7:0]   idx_q, idx_d;
  logic         out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic         out_eof_q, out_eof_d, out_msg_q, out_msg_d;
  logic [M-1:0] out_data_q, out_data_d;
  logic         frame_done_q, frame_done_d;
  logic         ovf_q, ovf_d, align_q, align_d;

  logic         full, rd_beat, start, take, last, wr_acc;
  logic [7:0]   cur_idx;

  always_comb begin
    full    = (occ_q == OCC_FULL);
    rd_beat = ecc_valid && (occ_q != 10'd0);
    start   = rd_beat && ecc_sof;
    // A beat consumes a buffered symbol only when it belongs to a frame.
    take    = rd_beat && (ecc_sof || state_q == S_ACTIVE);
    cur_idx = start ? 8'd0 : idx_q;
    last    = take && (cur_idx == LAST_IDX);
    wr_acc  = rx_valid && (!full || take);

    wr_ptr_d = wr_acc ? wr_ptr_q + 9'd1 : wr_ptr_q;
    rd_ptr_d = take ? rd_ptr_q + 9'd1 : rd_ptr_q;
    occ_d    = occ_q + {9'd0, wr_acc} - {9'd0, take};

    state_d = state_q;
    idx_d   = idx_q;
    if (take) begin
      state_d = last ? S_IDLE : S_ACTIVE;
      idx_d   = cur_idx + 8'd1;
    end

    out_valid_d  = take;
    out_sof_d    = start;
    out_eof_d    = last;
    out_msg_d    = take && (cur_idx < MSG_END);
    out_data_d   = mem[rd_ptr_q] ^ (err_flag ? err_mag : '0);
    frame_done_d = last;

    ovf_d   = ovf_q | (rx_valid && !wr_acc);
    align_d = align_q
            | (ecc_valid && occ_q == 10'd0)
            | (rd_beat && !ecc_sof && state_q == S_IDLE)
            | (rd_beat && ecc_sof && state_q == S_ACTIVE);
  end

  always_ff @(posedge clk_in) begin
    if (wr_acc) mem[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_msg_q    <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      align_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      out_msg_q    <= out_msg_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
      align_q      <= align_d;
    end
  end

  logic unused_in;

`ifdef RS_CORR_STATUS_EN
  logic [7:0] err_cnt_q, err_cnt_d, err_count_q, err_count_d, cnt_base, cnt_new;
  logic [3:0] deg_pend_q, deg_pend_d, deg_frame_q, deg_frame_d;
  logic       decode_fail_q, decode_fail_d;

  always_comb begin
    cnt_base      = start ? 8'd0 : err_cnt_q;
    cnt_new       = (err_flag && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
    err_cnt_d     = take ? cnt_new : err_cnt_q;
    deg_pend_d    = lambda_deg_valid ? lambda_deg : deg_pend_q;
    // A degree arriving on the sof beat itself belongs to this frame.
    deg_frame_d   = start ? (lambda_deg_valid ? lambda_deg : deg_pend_q) : deg_frame_q;
    err_count_d   = last ? cnt_new : err_count_q;
    decode_fail_d = last ? ((cnt_new != {4'd0, deg_frame_q}) || (deg_frame_q > T_MAX))
                         : decode_fail_q;
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_cnt_q     <= '0;
      err_count_q   <= '0;
      deg_pend_q    <= '0;
      deg_frame_q   <= '0;
      decode_fail_q <= 1'b0;
    end else begin
      err_cnt_q     <= err_cnt_d;
      err_count_q   <= err_count_d;
      deg_pend_q    <= deg_pend_d;
      deg_frame_q   <= deg_frame_d;
      decode_fail_q <= decode_fail_d;
    end
  end

  assign decode_fail = decode_fail_q;
  assign err_count   = err_count_q;
  assign unused_in   = rx_sof;
`else
  assign decode_fail = 1'b0;
  assign err_count   = 8'd0;
  assign unused_in   = ^{rx_sof, lambda_deg_valid, lambda_deg};
`endif

  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign out_msg    = out_msg_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign buf_full   = full;
  assign ovf_err    = ovf_q;
  assign align_err  = align_q;
endmodule
